// File: rtl/word40_assembler_pkg.sv
// Shared constants and types for the 40-bit word assembler.
package word40_assembler_pkg;

  localparam int W40_BYTES = 5;
  localparam int W40_WIDTH = 40;
  localparam logic [7:0] PAD_DEFAULT = 8'hFF;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [W40_WIDTH-1:0] pad_word(input logic [7:0] pad);
    return {W40_BYTES{pad}};
  endfunction

endpackage

// File: rtl/word40_assembler_lane_sel.sv
// Decodes a byte index 0..4 into a one-hot lane write enable, honouring lane order.
module word40_assembler_lane_sel
  import word40_assembler_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [2:0]           idx,
  output logic [W40_BYTES-1:0] lane_en
);

  always_comb begin
    lane_en = '0;
    for (int k = 0; k < W40_BYTES; k++) begin
      if (idx == 3'(k)) begin
        lane_en[LSB_FIRST ? k : (W40_BYTES - 1 - k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word40_assembler.sv
// Packs a valid/ready byte stream into 40-bit words with a held write strobe;
// short words (in_last) leave their upper lanes at PAD_BYTE.
module word40_assembler
  import word40_assembler_pkg::*;
#(
  parameter bit         LSB_FIRST = 1'b1,
  parameter logic [7:0] PAD_BYTE  = PAD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [W40_WIDTH-1:0] out_data,
  output logic [2:0]           out_count,
  output logic                 out_wr_en,
  input  logic                 out_ready
);

  state_t                 state, state_nxt;
  logic [2:0]             cnt, cnt_nxt;
  logic [2:0]             out_count_nxt;
  logic [W40_WIDTH-1:0]   data_nxt;
  logic [W40_WIDTH-1:0]   base;
  logic [2:0]             idx;
  logic [W40_BYTES-1:0]   lane_en;
  logic                   drain;
  logic                   accept;
  logic                   word_done;

  // A word being drained this cycle frees the lanes, so an incoming byte
  // restarts at lane 0 on a fresh pad background.
  assign drain     = (state == EMIT) & out_ready;
  assign accept    = in_valid & in_ready;
  assign idx       = (state == EMIT) ? 3'd0 : cnt;
  assign base      = (state == EMIT) ? pad_word(PAD_BYTE) : out_data;
  assign word_done = accept & ((idx == 3'd4) | in_last);

  word40_assembler_lane_sel #(
    .LSB_FIRST (LSB_FIRST)
  ) u_lane_sel (
    .idx     (idx),
    .lane_en (lane_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (word_done) begin
      state_nxt = EMIT;
    end else if (drain) begin
      state_nxt = FILL;
    end
  end

  always_comb begin
    in_ready  = (state == FILL) | drain;
    out_wr_en = (state == EMIT);
  end

  always_comb begin
    cnt_nxt       = cnt;
    out_count_nxt = out_count;
    data_nxt      = out_data;
    if (accept) begin
      for (int k = 0; k < W40_BYTES; k++) begin
        data_nxt[8*k +: 8] = lane_en[k] ? in_data : base[8*k +: 8];
      end
      if (word_done) begin
        cnt_nxt       = 3'd0;
        out_count_nxt = idx + 3'd1;
      end else begin
        cnt_nxt       = idx + 3'd1;
        out_count_nxt = 3'd0;
      end
    end else if (drain) begin
      data_nxt      = pad_word(PAD_BYTE);
      out_count_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd0;
      out_count <= 3'd0;
      out_data  <= pad_word(PAD_BYTE);
    end else begin
      cnt       <= cnt_nxt;
      out_count <= out_count_nxt;
      out_data  <= data_nxt;
    end
  end

endmodule
